// File: rtl/block_state_memory_if.sv
// block_state_memory_if
//   Bundles the render read port, the kill request/acknowledge handshake and
//   the level status outputs of block_state_memory.
//   master : game side (renderer, collision logic, game FSM)
//   slave  : block_state_memory
// Signals:
//   BLOCK_ADDR  (m->s) render read address
//   BLOCK_ALIVE (s->m) registered alive bit for last sampled BLOCK_ADDR
//   LEVEL_LOAD  (m->s) single-cycle pulse, refill all blocks alive
//   KILL_REQ    (m->s) kill request, held until KILL_ACK
//   KILL_ADDR   (m->s) block to kill, stable while KILL_REQ is high
//   KILL_ACK    (s->m) single-cycle completion pulse
//   KILL_HIT    (s->m) valid with KILL_ACK, 1 = live block was killed
//   ALIVE_COUNT (s->m) number of alive blocks
//   READY       (s->m) low while the memory is being refilled
//   ALL_CLEARED (s->m) READY and no block alive
//   STATE_DBG   (s->m) current FSM state (0 INIT, 1 IDLE, 2 CHECK)
// Handshake: the requester raises KILL_REQ with a stable KILL_ADDR and holds
// both until it sees KILL_ACK=1 for one cycle; it may then drop KILL_REQ.
// A request held through the ACK cycle is not accepted a second time.
interface block_state_memory_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] BLOCK_ADDR;
  logic              BLOCK_ALIVE;
  logic              LEVEL_LOAD;
  logic              KILL_REQ;
  logic [ADDR_W-1:0] KILL_ADDR;
  logic              KILL_ACK;
  logic              KILL_HIT;
  logic [ADDR_W-1:0] ALIVE_COUNT;
  logic              READY;
  logic              ALL_CLEARED;
  logic [1:0]        STATE_DBG;

  modport master (
    output BLOCK_ADDR, LEVEL_LOAD, KILL_REQ, KILL_ADDR,
    input  BLOCK_ALIVE, KILL_ACK, KILL_HIT, ALIVE_COUNT, READY, ALL_CLEARED,
           STATE_DBG
  );

  modport slave (
    input  BLOCK_ADDR, LEVEL_LOAD, KILL_REQ, KILL_ADDR,
    output BLOCK_ALIVE, KILL_ACK, KILL_HIT, ALIVE_COUNT, READY, ALL_CLEARED,
           STATE_DBG
  );
endinterface

// File: rtl/block_state_memory.sv
// block_state_memory
//   Owns the alive/dead bit of every breakout block. Refills all blocks alive
//   on reset or level load, serves the renderer's one-cycle-latency read port,
//   and executes kill requests from the collision logic, reporting whether a
//   live block was hit and keeping a running alive count.
// Ports:
//   CLK     rising-edge clock
//   RESET_N synchronous active-low reset
//   bus     block_state_memory_if.slave (render port, kill handshake, status)
module block_state_memory #(
  parameter int ROWS   = 7,
  parameter int COLS   = 10,
  parameter int ADDR_W = 7
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  block_state_memory_if.slave  bus
);
  localparam int N_BLOCKS = ROWS * COLS;
  localparam logic [ADDR_W-1:0] N_A   = ADDR_W'(N_BLOCKS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N_BLOCKS - 1);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_CHECK = 2'd2} state_t;

  logic              mem [0:N_BLOCKS-1];

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_addr;
  logic              r_pend;
  logic              r_phase;     // CHECK: 0 = reading mem, 1 = deciding
  logic              r_rd_alive;  // registered mem[r_addr] (0 if out of range)
  logic              r_ack;
  logic              r_hit;
  logic              r_alive;
  logic              r_ready;

  state_t            w_next_state;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [ADDR_W-1:0] w_count_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_pend_nxt;
  logic              w_phase_nxt;
  logic              w_ack_nxt;
  logic              w_hit_nxt;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic              w_wdata;

  always_comb begin
    w_next_state = r_state;
    w_ptr_nxt    = r_ptr;
    w_count_nxt  = r_count;
    w_addr_nxt   = r_addr;
    w_pend_nxt   = r_pend;
    w_phase_nxt  = r_phase;
    w_ack_nxt    = 1'b0;
    w_hit_nxt    = r_hit;
    w_we         = 1'b0;
    w_waddr      = r_ptr;
    w_wdata      = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (bus.LEVEL_LOAD) begin
          // Restart the refill from the first block.
          w_ptr_nxt   = '0;
          w_count_nxt = '0;
        end else begin
          w_we        = 1'b1;
          w_waddr     = r_ptr;
          w_wdata     = 1'b1;
          w_count_nxt = r_count + ONE;
          w_ptr_nxt   = r_ptr + ONE;
          if (r_ptr == LAST) w_next_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.LEVEL_LOAD || r_pend) begin
          w_next_state = ST_INIT;
          w_ptr_nxt    = '0;
          w_count_nxt  = '0;
          w_pend_nxt   = 1'b0;
        end else if (bus.KILL_REQ && !r_ack) begin
          // r_ack guard: a REQ still high in the ACK cycle is the old one.
          w_addr_nxt   = bus.KILL_ADDR;
          w_phase_nxt  = 1'b0;
          w_next_state = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bus.LEVEL_LOAD) w_pend_nxt = 1'b1;
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_ack_nxt = 1'b1;
          if (r_rd_alive) begin
            w_we        = 1'b1;
            w_waddr     = r_addr;
            w_wdata     = 1'b0;
            w_count_nxt = r_count - ONE;
            w_hit_nxt   = 1'b1;
          end else begin
            w_hit_nxt   = 1'b0;
          end
          if (r_pend || bus.LEVEL_LOAD) begin
            w_next_state = ST_INIT;
            w_ptr_nxt    = '0;
            w_count_nxt  = '0;
            w_pend_nxt   = 1'b0;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: begin
        w_next_state = ST_INIT;
        w_ptr_nxt    = '0;
        w_count_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state    <= ST_INIT;
      r_ptr      <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_pend     <= 1'b0;
      r_phase    <= 1'b0;
      r_rd_alive <= 1'b0;
      r_ack      <= 1'b0;
      r_hit      <= 1'b0;
      r_alive    <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_ptr      <= w_ptr_nxt;
      r_count    <= w_count_nxt;
      r_addr     <= w_addr_nxt;
      r_pend     <= w_pend_nxt;
      r_phase    <= w_phase_nxt;
      r_ack      <= w_ack_nxt;
      r_hit      <= w_hit_nxt;
      r_ready    <= (w_next_state != ST_INIT);
      if (r_state == ST_CHECK && !r_phase)
        r_rd_alive <= (r_addr < N_A) ? mem[r_addr] : 1'b0;
      // Reads the pre-write value when a kill writes the same address this edge.
      r_alive    <= (bus.BLOCK_ADDR < N_A && r_state != ST_INIT) ?
                    mem[bus.BLOCK_ADDR] : 1'b0;
    end
  end

  // Contents are deliberately not reset; INIT overwrites every entry.
  always_ff @(posedge CLK) begin
    if (RESET_N && w_we) mem[w_waddr] <= w_wdata;
  end

  assign bus.BLOCK_ALIVE = r_alive;
  assign bus.KILL_ACK    = r_ack;
  assign bus.KILL_HIT    = r_hit;
  assign bus.ALIVE_COUNT = r_count;
  assign bus.READY       = r_ready;
  assign bus.ALL_CLEARED = r_ready && (r_count == '0);
  assign bus.STATE_DBG   = r_state;
endmodule

// File: tb/tb_block_state_memory.sv
module tb_block_state_memory;
  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  block_state_memory_if #(.ADDR_W(7)) bus();

  block_state_memory #(.ROWS(7), .COLS(10), .ADDR_W(7)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic m_alive [0:69];
  int   exp_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.READY && n < 200) begin
      tick();
      n++;
    end
    if (!bus.READY) n = -1;
  endtask

  // Issues a kill, holds REQ one cycle past ACK, then watches for re-acks.
  task automatic do_kill(input logic [6:0] a, output logic hit,
                         output logic alive_at_ack, output logic alive_next);
    int   lat;
    logic extra_ack;
    bus.KILL_ADDR = a;
    bus.KILL_REQ  = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.KILL_ACK && lat < 300);
    chk("kill_lat", lat, 3);
    hit          = bus.KILL_HIT;
    alive_at_ack = bus.BLOCK_ALIVE;
    tick();
    alive_next = bus.BLOCK_ALIVE;
    extra_ack  = bus.KILL_ACK;
    bus.KILL_REQ = 1'b0;
    tick();
    extra_ack = extra_ack | bus.KILL_ACK;
    tick();
    extra_ack = extra_ack | bus.KILL_ACK;
    chk("ack_single_pulse", extra_ack, 0);
  endtask

  initial begin
    int   n;
    int   lat;
    logic hit, a_ack, a_nxt;
    RESET_N        = 1'b0;
    bus.BLOCK_ADDR = '0;
    bus.LEVEL_LOAD = 1'b0;
    bus.KILL_REQ   = 1'b0;
    bus.KILL_ADDR  = '0;
    repeat (3) tick();
    chk("rst_ready", bus.READY, 0);
    chk("rst_count", bus.ALIVE_COUNT, 0);
    chk("rst_ack", bus.KILL_ACK, 0);
    chk("rst_alive", bus.BLOCK_ALIVE, 0);
    chk("rst_state", bus.STATE_DBG, 0);

    RESET_N = 1'b1;
    wait_ready(n);
    chk("init_cycles", n, 70);
    chk("init_count", bus.ALIVE_COUNT, 70);
    chk("init_cleared", bus.ALL_CLEARED, 0);
    chk("idle_state", bus.STATE_DBG, 1);
    for (int i = 0; i < 70; i++) m_alive[i] = 1'b1;
    exp_count = 70;

    for (int a = 0; a < 70; a++) begin
      bus.BLOCK_ADDR = 7'(a);
      tick();
      chk("render_init", bus.BLOCK_ALIVE, 1);
    end
    bus.BLOCK_ADDR = 7'd70;  tick(); chk("render_70", bus.BLOCK_ALIVE, 0);
    bus.BLOCK_ADDR = 7'd127; tick(); chk("render_127", bus.BLOCK_ALIVE, 0);

    do_kill(7'd23, hit, a_ack, a_nxt);
    chk("kill23_hit", hit, 1);
    m_alive[23] = 1'b0; exp_count--;
    chk("kill23_count", bus.ALIVE_COUNT, exp_count);
    bus.BLOCK_ADDR = 7'd23; tick();
    chk("render23_dead", bus.BLOCK_ALIVE, 0);
    do_kill(7'd23, hit, a_ack, a_nxt);
    chk("kill23_again_hit", hit, 0);
    chk("kill23_again_count", bus.ALIVE_COUNT, exp_count);

    do_kill(7'd100, hit, a_ack, a_nxt);
    chk("kill100_hit", hit, 0);
    chk("kill100_count", bus.ALIVE_COUNT, exp_count);

    bus.BLOCK_ADDR = 7'd5; tick();
    do_kill(7'd5, hit, a_ack, a_nxt);
    chk("kill5_hit", hit, 1);
    chk("rbw_old_value", a_ack, 1);
    chk("rbw_next_read", a_nxt, 0);
    m_alive[5] = 1'b0; exp_count--;
    chk("kill5_count", bus.ALIVE_COUNT, exp_count);

    for (int a = 0; a < 70; a++) begin
      do_kill(7'(a), hit, a_ack, a_nxt);
      chk("killall_hit", hit, m_alive[a]);
      if (m_alive[a]) exp_count--;
      m_alive[a] = 1'b0;
    end
    chk("killall_count", bus.ALIVE_COUNT, 0);
    chk("killall_cleared", bus.ALL_CLEARED, 1);
    chk("killall_ready", bus.READY, 1);

    bus.LEVEL_LOAD = 1'b1; tick(); bus.LEVEL_LOAD = 1'b0;
    chk("load_ready_low", bus.READY, 0);
    chk("load_cleared_low", bus.ALL_CLEARED, 0);
    wait_ready(n);
    chk("load_cycles", n, 70);
    chk("load_count", bus.ALIVE_COUNT, 70);

    // LEVEL_LOAD and KILL_REQ together: load wins, kill served after INIT.
    bus.LEVEL_LOAD = 1'b1;
    bus.KILL_REQ   = 1'b1;
    bus.KILL_ADDR  = 7'd3;
    tick();
    bus.LEVEL_LOAD = 1'b0;
    lat = 1;
    while (!bus.KILL_ACK && lat < 300) begin
      tick();
      lat++;
    end
    chk("load_kill_lat", lat, 74);
    chk("load_kill_hit", bus.KILL_HIT, 1);
    bus.KILL_REQ = 1'b0;
    tick();
    chk("load_kill_count", bus.ALIVE_COUNT, 69);

    // LEVEL_LOAD during CHECK: kill still acks, INIT follows.
    bus.KILL_ADDR = 7'd10;
    bus.KILL_REQ  = 1'b1;
    tick();
    bus.LEVEL_LOAD = 1'b1; tick(); bus.LEVEL_LOAD = 1'b0;
    chk("chk_load_noack_yet", bus.KILL_ACK, 0);
    tick();
    chk("chk_load_ack", bus.KILL_ACK, 1);
    chk("chk_load_hit", bus.KILL_HIT, 1);
    chk("chk_load_ready", bus.READY, 0);
    bus.KILL_REQ = 1'b0;
    wait_ready(n);
    chk("chk_load_cycles", n, 70);
    chk("chk_load_count", bus.ALIVE_COUNT, 70);
    bus.BLOCK_ADDR = 7'd10; tick();
    chk("render10_reloaded", bus.BLOCK_ALIVE, 1);

    // Reset in the middle of INIT.
    bus.LEVEL_LOAD = 1'b1; tick(); bus.LEVEL_LOAD = 1'b0;
    repeat (30) tick();
    chk("midinit_count", bus.ALIVE_COUNT, 30);
    chk("midinit_render", bus.BLOCK_ALIVE, 0);
    RESET_N = 1'b0; tick();
    chk("midrst_count", bus.ALIVE_COUNT, 0);
    chk("midrst_ready", bus.READY, 0);
    RESET_N = 1'b1;
    wait_ready(n);
    chk("midrst_cycles", n, 70);
    chk("midrst_count_full", bus.ALIVE_COUNT, 70);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
